// File: rtl/nanorv32_datamem_responder_pkg.sv
// Shared FSM state encodings, bytesel codes and access-legality helper for the
// nanorv32 data-memory responder.
package nanorv32_datamem_responder_pkg;

  typedef enum logic [1:0] {
    NRV32_DMEM_ST_IDLE = 2'd0,
    NRV32_DMEM_ST_WAIT = 2'd1,
    NRV32_DMEM_ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] NRV32_BYTESEL_READ = 4'b0000;

  // 1 when the bytesel pattern is illegal or not naturally aligned to addr[1:0].
  function automatic logic nrv32_access_misaligned(input logic [3:0] bsel,
                                                   input logic [1:0] alo);
    case (bsel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b0;
      4'b0011, 4'b1100:                   return alo[0];
      4'b1111, NRV32_BYTESEL_READ:        return (alo != 2'b00);
      default:                            return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/nanorv32_datamem_responder_sram_1rw.sv
// Single-port synchronous 32-bit word RAM with per-byte write enables.
// Read data is registered and only updated by read cycles (we == 0).
module nanorv32_sram_1rw #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      if (i_we == 4'b0000) r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/nanorv32_datamem_responder.sv
// Memory-side responder for the nanorv32 data bus: capture, wait states, one-cycle ready.
// Optional error reporting with `define NANORV32_DATAMEM_ERR_EN.
module nanorv32_datamem_responder
  import nanorv32_datamem_responder_pkg::*;
#(
  parameter int unsigned MEM_AW      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_datamem_addr,
  input  logic [31:0] cpu_datamem_wdata,
  input  logic [3:0]  cpu_datamem_bytesel,
  input  logic        cpu_datamem_valid,
  output logic [31:0] datamem_cpu_rdata,
`ifdef NANORV32_DATAMEM_ERR_EN
  output logic        datamem_cpu_err,
`endif
  output logic        datamem_cpu_ready
);

  localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e       r_state, w_next;
  logic [3:0]        r_cnt;
  logic [MEM_AW-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_bsel;
  logic              r_ok;

  logic              w_in_win, w_req_ok, w_capture;
  logic              w_idle, w_is_read, w_ram_ok, w_rd_en;
  logic [3:0]        w_we;
  logic [MEM_AW-1:0] w_ram_addr;
  logic [31:0]       w_ram_q;

  // Base is window-aligned, so the window test reduces to comparing the upper bits.
  assign w_in_win = (cpu_datamem_addr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);

`ifdef NANORV32_DATAMEM_ERR_EN
  assign w_req_ok = w_in_win &&
                    !nrv32_access_misaligned(cpu_datamem_bytesel, cpu_datamem_addr[1:0]);
`else
  assign w_req_ok = w_in_win;
  logic w_unused;
  assign w_unused = ^cpu_datamem_addr[1:0];
`endif

  assign w_idle    = (r_state == NRV32_DMEM_ST_IDLE);
  assign w_capture = w_idle && cpu_datamem_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= NRV32_DMEM_ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      NRV32_DMEM_ST_IDLE:
        if (cpu_datamem_valid)
          w_next = (WAIT_STATES == 0) ? NRV32_DMEM_ST_RESP : NRV32_DMEM_ST_WAIT;
      NRV32_DMEM_ST_WAIT:
        if (!cpu_datamem_valid) w_next = NRV32_DMEM_ST_IDLE;
        else if (r_cnt == '0)   w_next = NRV32_DMEM_ST_RESP;
      NRV32_DMEM_ST_RESP: w_next = NRV32_DMEM_ST_IDLE;
      default:            w_next = NRV32_DMEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_bsel  <= '0;
      r_ok    <= 1'b0;
    end else if (w_capture) begin
      r_cnt   <= LP_CNT_INIT;
      r_idx   <= cpu_datamem_addr[MEM_AW+1:2];
      r_wdata <= cpu_datamem_wdata;
      r_bsel  <= cpu_datamem_bytesel;
      r_ok    <= w_req_ok;
    end else if (r_state == NRV32_DMEM_ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // With zero wait states the read issues from IDLE, before the request is captured,
  // so the RAM port takes the live request fields while idle.
  assign w_ram_addr = w_idle ? cpu_datamem_addr[MEM_AW+1:2] : r_idx;
  assign w_is_read  = w_idle ? (cpu_datamem_bytesel == NRV32_BYTESEL_READ)
                             : (r_bsel == NRV32_BYTESEL_READ);
  assign w_ram_ok   = w_idle ? w_req_ok : r_ok;
  assign w_rd_en    = (w_next == NRV32_DMEM_ST_RESP) && (r_state != NRV32_DMEM_ST_RESP) &&
                      w_is_read && w_ram_ok;
  assign w_we       = (r_state == NRV32_DMEM_ST_RESP && r_ok) ? r_bsel : 4'b0000;

  nanorv32_sram_1rw #(
    .AW(MEM_AW)
  ) u_sram (
    .clk    (clk),
    .i_en   (w_rd_en || (w_we != 4'b0000)),
    .i_we   (w_we),
    .i_addr (w_ram_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_q)
  );

  always_comb begin
    datamem_cpu_ready = 1'b0;
    datamem_cpu_rdata = '0;
`ifdef NANORV32_DATAMEM_ERR_EN
    datamem_cpu_err   = 1'b0;
`endif
    if (r_state == NRV32_DMEM_ST_RESP) begin
      datamem_cpu_ready = 1'b1;
      if (r_ok && r_bsel == NRV32_BYTESEL_READ) datamem_cpu_rdata = w_ram_q;
`ifdef NANORV32_DATAMEM_ERR_EN
      datamem_cpu_err = !r_ok;
`endif
    end
  end

endmodule

// File: tb/tb_nanorv32_datamem_responder.sv
// Scoreboard bench: three responders (WAIT_STATES 1, 0, 3) share a clock; the driver
// queues expected responses, a monitor checks every ready pulse and idle outputs.
module tb_nanorv32_datamem_responder;

`ifdef NANORV32_DATAMEM_ERR_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        s_rst_n [3];
  logic [31:0] s_addr  [3];
  logic [31:0] s_wdata [3];
  logic [3:0]  s_bsel  [3];
  logic        s_valid [3];
  logic [31:0] s_rdata [3];
  logic        s_ready [3];
`ifdef NANORV32_DATAMEM_ERR_EN
  logic        s_err   [3];
`endif

  exp_t sb[$];
  int   cyc      = 0;
  int   timeouts = 0;
  bit   done     = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nanorv32_datamem_responder #(
      .MEM_AW     (10),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk                (clk),
      .rst_n              (s_rst_n[g]),
      .cpu_datamem_addr   (s_addr[g]),
      .cpu_datamem_wdata  (s_wdata[g]),
      .cpu_datamem_bytesel(s_bsel[g]),
      .cpu_datamem_valid  (s_valid[g]),
      .datamem_cpu_rdata  (s_rdata[g]),
`ifdef NANORV32_DATAMEM_ERR_EN
      .datamem_cpu_err    (s_err[g]),
`endif
      .datamem_cpu_ready  (s_ready[g])
    );
  end

  function automatic int ws(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k);
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (s_ready[k]) break;
    end
    if (n == 30) timeouts++;
    step();
  endtask

  // Issue one request; valid stays high on return so back-to-back requests can follow.
  task automatic req(input int k, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] bs, input logic [31:0] er, input logic ee);
    exp_t e;
    s_addr[k]  = a;
    s_wdata[k] = wd;
    s_bsel[k]  = bs;
    s_valid[k] = 1'b1;
    e.inst  = k;
    e.rdata = er;
    e.err   = ee;
    e.cyc   = cyc + 1 + ws(k);
    sb.push_back(e);
    wait_ready(k);
  endtask

  task automatic idle(input int k);
    s_valid[k] = 1'b0;
    step();
  endtask

  // Driver
  initial begin
    for (int k = 0; k < 3; k++) begin
      s_rst_n[k] = 1'b0;
      s_addr[k]  = '0;
      s_wdata[k] = '0;
      s_bsel[k]  = '0;
      s_valid[k] = 1'b0;
    end
    repeat (3) step();
    for (int k = 0; k < 3; k++) s_rst_n[k] = 1'b1;
    repeat (2) step();

    // WAIT_STATES=1: word write/read, byte lanes, window edges, misaligned half-word
    req(0, 32'h10, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);              idle(0);
    req(0, 32'h10, 32'h0, 4'b0000, 32'h1234_5678, 1'b0);              idle(0);
    req(0, 32'h00, 32'h0, 4'b1111, 32'h0, 1'b0);                      idle(0);
    req(0, 32'h00, 32'hAABB_CCDD, 4'b0101, 32'h0, E);                 idle(0);
    req(0, 32'h00, 32'h0, 4'b0000, E ? 32'h0 : 32'h00BB_00DD, 1'b0);  idle(0);
    req(0, 32'h13, 32'h1100_0000, 4'b1000, 32'h0, 1'b0);              idle(0);
    req(0, 32'h10, 32'h0, 4'b0000, 32'h1134_5678, 1'b0);              idle(0);
    req(0, 32'h1000, 32'h0, 4'b0000, 32'h0, E);                       idle(0);
    req(0, 32'h1000, 32'h5555_5555, 4'b1111, 32'h0, E);               idle(0);
    req(0, 32'h00, 32'h0, 4'b0000, E ? 32'h0 : 32'h00BB_00DD, 1'b0);  idle(0);
    req(0, 32'h01, 32'h0000_9999, 4'b0011, 32'h0, E);                 idle(0);
    req(0, 32'h00, 32'h0, 4'b0000, E ? 32'h0 : 32'h00BB_9999, 1'b0);  idle(0);

    // Read abandoned during WAIT: no ready, then a normal read still works
    s_addr[0] = 32'h10; s_bsel[0] = 4'b0000; s_valid[0] = 1'b1;
    step();
    idle(0); idle(0);
    req(0, 32'h10, 32'h0, 4'b0000, 32'h1134_5678, 1'b0);              idle(0);

    // WAIT_STATES=0: back-to-back reads with valid held, plus last word of the window
    req(1, 32'h000, 32'hA5A5_0001, 4'b1111, 32'h0, 1'b0);             idle(1);
    req(1, 32'h004, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);             idle(1);
    req(1, 32'hFFC, 32'hFEED_0FFC, 4'b1111, 32'h0, 1'b0);             idle(1);
    req(1, 32'h000, 32'h0, 4'b0000, 32'hA5A5_0001, 1'b0);
    req(1, 32'h004, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0);
    req(1, 32'hFFC, 32'h0, 4'b0000, 32'hFEED_0FFC, 1'b0);             idle(1);

    // WAIT_STATES=3: reset during WAIT of a write drops the write
    req(2, 32'h20, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);              idle(2);
    s_addr[2] = 32'h20; s_wdata[2] = 32'hDEAD_BEEF; s_bsel[2] = 4'b1111; s_valid[2] = 1'b1;
    step(); step();
    s_rst_n[2] = 1'b0;
    step();
    s_valid[2] = 1'b0;
    step();
    s_rst_n[2] = 1'b1;
    repeat (6) step();
    req(2, 32'h20, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0);              idle(2);

    repeat (4) step();
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (s_ready[k]) begin
          total++;
          if (sb.size() == 0 || sb[0].inst != k) begin
            bad++;
            $display("FAIL unexpected_ready inst=%0d cyc=%0d", k, cyc);
          end else begin
            e = sb.pop_front();
            if (s_rdata[k] !== e.rdata) begin
              bad++;
              $display("FAIL rdata inst=%0d got=%h exp=%h", k, s_rdata[k], e.rdata);
            end
            total++;
            if (cyc != e.cyc) begin
              bad++;
              $display("FAIL latency inst=%0d got_cyc=%0d exp_cyc=%0d", k, cyc, e.cyc);
            end
`ifdef NANORV32_DATAMEM_ERR_EN
            total++;
            if (s_err[k] !== e.err) begin
              bad++;
              $display("FAIL err inst=%0d got=%b exp=%b", k, s_err[k], e.err);
            end
`endif
          end
        end else begin
          total++;
          if (s_ready[k] !== 1'b0 || s_rdata[k] !== 32'h0) begin
            bad++;
            $display("FAIL idle_out inst=%0d ready=%b rdata=%h exp 0/0", k, s_ready[k], s_rdata[k]);
          end
`ifdef NANORV32_DATAMEM_ERR_EN
          total++;
          if (s_err[k] !== 1'b0) begin
            bad++;
            $display("FAIL idle_err inst=%0d got=%b exp=0", k, s_err[k]);
          end
`endif
        end
      end
    end
    total++;
    if (timeouts != 0) begin
      bad++;
      $display("FAIL ready_timeout count=%0d exp=0", timeouts);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_responses left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
